// File: rtl/bw_seq_mult_ctrl_if.sv
// Handshake bundle for bw_seq_mult_ctrl: operand channel in, product channel out, busy status.
// Latency: none (wires only).
// Backpressure: in_ready_out gates operands, out_ready_in gates the product.
// Ports: in_valid_in/in_ready_out/a_in/b_in (operands), out_valid_out/out_ready_in/p_out (product), busy_out.
// Modports: slave = multiplier side, master = producer/consumer side.
interface bw_seq_mult_ctrl_if #(
    parameter int N = 8
);
    logic             in_valid_in;
    logic             in_ready_out;
    logic [N-1:0]     a_in;
    logic [N-1:0]     b_in;
    logic             out_valid_out;
    logic             out_ready_in;
    logic [2*N-1:0]   p_out;
    logic             busy_out;

    modport slave (
        input  in_valid_in,
        output in_ready_out,
        input  a_in,
        input  b_in,
        output out_valid_out,
        input  out_ready_in,
        output p_out,
        output busy_out
    );

    modport master (
        output in_valid_in,
        input  in_ready_out,
        output a_in,
        output b_in,
        input  out_valid_out,
        output out_ready_in,
        input  p_out,
        input  busy_out
    );
endinterface

// File: rtl/bw_seq_mult_ctrl.sv
// Sequential Baugh-Wooley signed multiplier: one row of N cells reused over N rows plus a carry-resolve cycle.
// Latency: N+1 edges from operand acceptance to out_valid_out (1 edge for zero operands with BW_SEQ_ZERO_SKIP_EN).
// Backpressure: product held in DONE with in_ready_out low until out_ready_in; no input queuing.
// Ports: clk_in (rising edge), rst_in (sync, active high), bus (bw_seq_mult_ctrl_if.slave):
//   in_valid_in/in_ready_out/a_in/b_in operand handshake, out_valid_out/out_ready_in/p_out product
//   handshake, busy_out high while computing.
// Build option: define BW_SEQ_ZERO_SKIP_EN to short-circuit zero operands straight to FINAL.
module bw_seq_mult_ctrl #(
    parameter int N = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    bw_seq_mult_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROW   = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);
    // Baugh-Wooley correction ones at product bits N and 2N-1, expressed
    // relative to the upper half that FINAL resolves.
    localparam logic [N-1:0] BW_CORR = N'(1) | (N'(1) << (N - 1));
    // Upper half of the partial-product vector (bit N-1) is inverted on
    // every row except the last; on the last row the lower bits are.
    localparam logic [N-1:0] INV_TOP = N'(1) << (N - 1);
    localparam logic [N-1:0] INV_LOW = ~INV_TOP;

    state_t             state_q,     state_d;
    logic [N-1:0]       a_q,         a_d;
    logic [N-1:0]       b_q,         b_d;
    logic [N-1:0]       sum_q,       sum_d;
    logic [N-1:0]       carry_q,     carry_d;
    logic [N-1:0]       plow_q,      plow_d;
    logic [CW-1:0]      row_cnt_q,   row_cnt_d;
    logic [2*N-1:0]     p_q,         p_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;
`ifdef BW_SEQ_ZERO_SKIP_EN
    logic               corr_en_q,   corr_en_d;
`endif

    // Row datapath (combinational, valid while in ROW)
    logic [N-1:0]       pp;
    logic [N-1:0]       sh_sum;
    logic [N-1:0]       row_sum;
    logic [N-1:0]       row_carry;
    logic [N-1:0]       corr;
    logic [N-1:0]       final_hi;

    always_comb begin
        pp        = (a_q & {N{b_q[row_cnt_q]}}) ^ ((row_cnt_q == LAST_ROW) ? INV_LOW : INV_TOP);
        // Sum bits move one position down per row since each row is one
        // weight higher; the top cell has no incoming sum.
        sh_sum    = {1'b0, sum_q[N-1:1]};
        row_sum   = pp ^ sh_sum ^ carry_q;
        row_carry = (pp & sh_sum) | (pp & carry_q) | (sh_sum & carry_q);
`ifdef BW_SEQ_ZERO_SKIP_EN
        corr      = corr_en_q ? BW_CORR : '0;
`else
        corr      = BW_CORR;
`endif
        // After the last row the carries already sit at the upper-half
        // weights; dropping overflow gives the result modulo 2^2N.
        final_hi  = sh_sum + carry_q + corr;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        plow_d    = plow_q;
        row_cnt_d = row_cnt_q;
        p_d       = p_q;
`ifdef BW_SEQ_ZERO_SKIP_EN
        corr_en_d = corr_en_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_in && in_ready_q) begin
                    a_d       = bus.a_in;
                    b_d       = bus.b_in;
                    sum_d     = '0;
                    carry_d   = '0;
                    plow_d    = '0;
                    row_cnt_d = '0;
                    state_d   = S_ROW;
`ifdef BW_SEQ_ZERO_SKIP_EN
                    corr_en_d = 1'b1;
                    if (bus.a_in == '0 || bus.b_in == '0) begin
                        corr_en_d = 1'b0;
                        state_d   = S_FINAL;
                    end
`endif
                end
            end
            S_ROW: begin
                sum_d             = row_sum;
                carry_d           = row_carry;
                plow_d[row_cnt_q] = row_sum[0];
                if (row_cnt_q == LAST_ROW) begin
                    row_cnt_d = '0;
                    state_d   = S_FINAL;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end
            S_FINAL: begin
                p_d     = {final_hi, plow_q};
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state they describe.
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d == S_ROW) || (state_d == S_FINAL);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            plow_q      <= '0;
            row_cnt_q   <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BW_SEQ_ZERO_SKIP_EN
            corr_en_q   <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            plow_q      <= plow_d;
            row_cnt_q   <= row_cnt_d;
            p_q         <= p_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef BW_SEQ_ZERO_SKIP_EN
            corr_en_q   <= corr_en_d;
`endif
        end
    end

    assign bus.in_ready_out  = in_ready_q;
    assign bus.out_valid_out = out_valid_q;
    assign bus.p_out         = p_q;
    assign bus.busy_out      = busy_q;

endmodule
